// File: rtl/weight_load_pkg.sv
// Shared types and helpers for the weight load controller.
package weight_load_pkg;

   localparam int unsigned WEIGHT_ADDR_WIDTH = 32;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StRun
   } state_e;

   // Bits needed for a counter that runs 0 .. limit-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned limit);
      return (limit <= 32'd2) ? 32'd1 : $clog2(limit);
   endfunction

endpackage

// File: rtl/weight_load_ctrl_if.sv
// Host weight stream in, weight memory write bus out.
interface weight_load_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 16
);
   import weight_load_pkg::*;

   logic [DATA_WIDTH-1:0]        s_data;
   logic                         s_valid;
   logic                         s_ready;
   logic [DATA_WIDTH-1:0]        weight_data;
   logic [WEIGHT_ADDR_WIDTH-1:0] weight_addr;
   logic                         weight_we;

   modport master (
      input  s_data, s_valid,
      output s_ready, weight_data, weight_addr, weight_we
   );

   modport slave (
      output s_data, s_valid,
      input  s_ready, weight_data, weight_addr, weight_we
   );

endinterface

// File: rtl/frame_pixel_counter.sv
// Modulo-LIMIT event counter; wrap pulses for one cycle after the LIMIT-th event.
module frame_pixel_counter
   import weight_load_pkg::*;
#(
   parameter int unsigned LIMIT = 131072
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic en,
   output logic wrap
);

   localparam int unsigned CW = cnt_width(LIMIT);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          wrap_q, wrap_d;
   logic          at_last;

   assign at_last = (cnt_q == CW'(LIMIT - 1));

   // clear beats a coincident event so a restarted frame begins at zero
   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (clear) begin
         cnt_d = '0;
      end else if (en) begin
         if (at_last) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
      end
   end

   assign wrap = wrap_q;

endmodule

// File: rtl/weight_load_ctrl.sv
// Loads a weight window from the host stream, then enables the conv chain and counts frames.
// Optional running-sum check of the loaded window: define WEIGHT_CHECKSUM_EN.
module weight_load_ctrl
   import weight_load_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned ADDR_BASE     = 0,
   parameter int unsigned TOTAL_WEIGHTS = 1024,
   parameter int unsigned OUT_PIXELS    = 131072
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_start,
   weight_load_ctrl_if.master    bus,
   input  logic                  i_valid,
   output logic                  i_valid_gated,
   input  logic                  pix_valid,
   output logic                  load_done,
   output logic                  frame_done,
   output logic                  busy,
   input  logic [DATA_WIDTH-1:0] cfg_checksum,
   output logic                  checksum_err
);

   localparam int unsigned WCW = cnt_width(TOTAL_WEIGHTS);

   state_e                       state_q, state_d;
   logic [WCW-1:0]               word_cnt_q, word_cnt_d;
   logic [DATA_WIDTH-1:0]        weight_data_q;
   logic [WEIGHT_ADDR_WIDTH-1:0] weight_addr_q;
   logic                         weight_we_q;

   logic accept;
   logic last_word;
   logic start;

   assign accept    = bus.s_valid && (state_q == StLoad);
   assign last_word = accept && (word_cnt_q == WCW'(TOTAL_WEIGHTS - 1));
   // cfg_start is ignored while loading
   assign start     = cfg_start && (state_q != StLoad);

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      case (state_q)
         StIdle: begin
            if (cfg_start) begin
               state_d    = StLoad;
               word_cnt_d = '0;
            end
         end
         StLoad: begin
            if (last_word) begin
               state_d    = StRun;
               word_cnt_d = '0;
            end else if (accept) begin
               word_cnt_d = word_cnt_q + WCW'(1);
            end
         end
         StRun: begin
            if (cfg_start) begin
               state_d    = StLoad;
               word_cnt_d = '0;
            end
         end
         default: begin
            state_d    = StIdle;
            word_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         word_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   // Write port registers: one strobe per accepted word, one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         weight_we_q   <= 1'b0;
         weight_data_q <= '0;
         weight_addr_q <= '0;
      end else begin
         weight_we_q <= accept;
         if (accept) begin
            weight_data_q <= bus.s_data;
            weight_addr_q <= WEIGHT_ADDR_WIDTH'(ADDR_BASE) + WEIGHT_ADDR_WIDTH'(word_cnt_q);
         end
      end
   end

   assign bus.weight_we   = weight_we_q;
   assign bus.weight_data = weight_data_q;
   assign bus.weight_addr = weight_addr_q;
   assign bus.s_ready     = (state_q == StLoad);

   assign busy          = (state_q == StLoad);
   assign load_done     = (state_q == StRun);
   assign i_valid_gated = i_valid & load_done;

   frame_pixel_counter #(
      .LIMIT (OUT_PIXELS)
   ) u_frame_pixel_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (start),
      .en    (pix_valid && (state_q == StRun)),
      .wrap  (frame_done)
   );

`ifdef WEIGHT_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] sum_q;
   logic [DATA_WIDTH-1:0] sum_next;
   logic                  checksum_err_q;

   assign sum_next = sum_q + bus.s_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q          <= '0;
         checksum_err_q <= 1'b0;
      end else if (start) begin
         sum_q          <= '0;
         checksum_err_q <= 1'b0;
      end else if (accept) begin
         sum_q <= sum_next;
         if (last_word) begin
            checksum_err_q <= (sum_next != cfg_checksum);
         end
      end
   end

   assign checksum_err = checksum_err_q;
`else
   logic unused_cfg_checksum;
   assign unused_cfg_checksum = ^cfg_checksum;
   assign checksum_err        = 1'b0;
`endif

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Randomized self-checking bench for weight_load_ctrl against a cycle-level behavioural model.
module tb_weight_load_ctrl;

   localparam int unsigned DW   = 16;
   localparam int unsigned BASE = 23;
   localparam int unsigned TW   = 4;
   localparam int unsigned OP   = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_start = 1'b0;
   logic          i_valid = 1'b0;
   logic          pix_valid = 1'b0;
   logic [DW-1:0] cfg_cs = '0;
   logic          i_valid_gated, load_done, frame_done, busy, checksum_err;

   weight_load_ctrl_if #(.DATA_WIDTH(DW)) bus ();

   weight_load_ctrl #(
      .DATA_WIDTH    (DW),
      .ADDR_BASE     (BASE),
      .TOTAL_WEIGHTS (TW),
      .OUT_PIXELS    (OP)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_start     (cfg_start),
      .bus           (bus),
      .i_valid       (i_valid),
      .i_valid_gated (i_valid_gated),
      .pix_valid     (pix_valid),
      .load_done     (load_done),
      .frame_done    (frame_done),
      .busy          (busy),
      .cfg_checksum  (cfg_cs),
      .checksum_err  (checksum_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: loading/running flags plus plain integer counts.
   bit          m_loading, m_done, m_err;
   int          m_k, m_pix;
   logic [DW-1:0] m_sum;
   bit          e_we, e_fd;
   logic [31:0] e_addr;
   logic [DW-1:0] e_data;
   bit          obs_gated, exp_gated;

   task automatic model_reset();
      m_loading = 0; m_done = 0; m_err = 0;
      m_k = 0; m_pix = 0; m_sum = '0;
      e_we = 0; e_fd = 0; e_addr = '0; e_data = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; cfg_start = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
      pix_valid = 1'b0; i_valid = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drive one cycle of inputs, sample the combinational gate, advance the model, return at edge+1.
   task automatic tick(input bit cfg, input bit v, input logic [DW-1:0] d,
                       input bit pix, input bit iv);
      bit pre_load, pre_done;
      @(negedge clk);
      cfg_start = cfg; bus.s_valid = v; bus.s_data = d; pix_valid = pix; i_valid = iv;
      #1;
      obs_gated = i_valid_gated;
      exp_gated = iv & m_done;
      @(posedge clk);
      pre_load = m_loading;
      pre_done = m_done;
      e_we = pre_load && v;
      e_fd = 0;
      if (e_we) begin
         e_addr = 32'(BASE + m_k);
         e_data = d;
         m_sum  = m_sum + d;
         m_k++;
         if (m_k == TW) begin
            m_loading = 0;
            m_done    = 1;
`ifdef WEIGHT_CHECKSUM_EN
            m_err = (m_sum != cfg_cs);
`endif
         end
      end
      if (cfg && !pre_load) begin
         m_loading = 1; m_done = 0; m_k = 0; m_sum = '0; m_err = 0; m_pix = 0;
      end else if (pre_done && pix) begin
         m_pix++;
         if (m_pix == OP) begin
            m_pix = 0;
            e_fd  = 1;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      logic [DW+32+5:0] obs;
      #1;
      obs = {bus.s_ready, bus.weight_we, load_done, frame_done, busy, checksum_err,
             bus.weight_data, bus.weight_addr};
      n_cmp++;
      if (obs !== '0) begin
         n_err++;
         $display("FAIL reset_initial: outputs=%h required=0", obs);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick(1, 0, '0, 0, 0);
      tick(0, 1, 16'hAAAA, 0, 0);
      tick(0, 1, 16'hBBBB, 0, 0);
      #1;
      rst_n = 1'b0;
      #1;
      obs = {bus.s_ready, bus.weight_we, load_done, frame_done, busy, checksum_err,
             bus.weight_data, bus.weight_addr};
      n_cmp++;
      if (obs !== '0) begin
         n_err++;
         $display("FAIL reset_midload: outputs=%h required=0", obs);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick(1, 0, '0, 0, 0);
      tick(0, 1, 16'h1234, 0, 0);
      n_cmp++;
      if ({bus.weight_we, bus.weight_addr, bus.weight_data} !== {1'b1, 32'd23, 16'h1234}) begin
         n_err++;
         $display("FAIL reset_reload: we/addr/data=%b/%0d/%h required=1/23/1234",
                  bus.weight_we, bus.weight_addr, bus.weight_data);
      end
   endtask

   task automatic test_continuous_load();
      do_reset();
      tick(1, 0, '0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tick(0, 1, 16'(16'h0101 + i), 0, 0);
         n_cmp++;
         if ({bus.weight_we, bus.weight_addr, bus.weight_data}
             !== {1'b1, 32'(BASE + i), 16'(16'h0101 + i)}) begin
            n_err++;
            $display("FAIL cont_write%0d: we/addr/data=%b/%0d/%h required=1/%0d/%h", i,
                     bus.weight_we, bus.weight_addr, bus.weight_data, BASE + i, 16'h0101 + i);
         end
         n_cmp++;
         if ({load_done, bus.s_ready} !== {m_done, m_loading}) begin
            n_err++;
            $display("FAIL cont_status%0d: load_done/s_ready=%b%b required=%b%b", i,
                     load_done, bus.s_ready, m_done, m_loading);
         end
      end
      tick(0, 1, 16'hDEAD, 0, 0);
      n_cmp++;
      if ({bus.weight_we, bus.weight_addr, load_done} !== {1'b0, 32'd26, 1'b1}) begin
         n_err++;
         $display("FAIL cont_extra: we/addr/load_done=%b/%0d/%b required=0/26/1",
                  bus.weight_we, bus.weight_addr, load_done);
      end
   endtask

   task automatic test_gapped();
      do_reset();
      tick(1, 0, '0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         tick((i == 2) || (i == 5), (i % 2) == 0, 16'($urandom), 0, 0);
         n_cmp++;
         if ({bus.weight_we, bus.weight_addr, bus.weight_data, busy, load_done}
             !== {e_we, e_addr, e_data, m_loading, m_done}) begin
            n_err++;
            $display("FAIL gapped%0d: we/addr/data/busy/done=%b/%0d/%h/%b/%b required=%b/%0d/%h/%b/%b",
                     i, bus.weight_we, bus.weight_addr, bus.weight_data, busy, load_done,
                     e_we, e_addr, e_data, m_loading, m_done);
         end
      end
   endtask

   task automatic test_gating();
      do_reset();
      tick(0, 0, '0, 0, 1);
      tick(1, 0, '0, 0, 1);
      for (int i = 0; i < 7; i++) begin
         tick(0, 1'($urandom), 16'($urandom), 0, 1);
         n_cmp++;
         if (obs_gated !== exp_gated) begin
            n_err++;
            $display("FAIL gating%0d: i_valid_gated=%b required=%b", i, obs_gated, exp_gated);
         end
      end
      tick(1, 0, '0, 0, 1);
      tick(0, 0, '0, 0, 1);
      n_cmp++;
      if (obs_gated !== 1'b0) begin
         n_err++;
         $display("FAIL gating_restart: i_valid_gated=%b required=0", obs_gated);
      end
   endtask

   task automatic test_frames();
      int pulses, frames;
      do_reset();
      tick(0, 0, '0, 1, 0);
      tick(0, 0, '0, 1, 0);
      tick(1, 0, '0, 1, 0);
      for (int i = 0; i < 4; i++) tick(0, 1, 16'($urandom), 1, 0);
      pulses = 0;
      frames = 0;
      for (int i = 0; i < 14; i++) begin
         bit p;
         p = (pulses < 7) && ((i < 4) || ($urandom_range(0, 1) == 1));
         if (p) pulses++;
         tick(0, 0, '0, p, 0);
         if (frame_done === 1'b1) frames++;
         n_cmp++;
         if (frame_done !== e_fd) begin
            n_err++;
            $display("FAIL frame%0d: frame_done=%b required=%b", i, frame_done, e_fd);
         end
      end
      n_cmp++;
      if (frames !== 2) begin
         n_err++;
         $display("FAIL frame_count: frames=%0d after %0d pulses required=2", frames, pulses);
      end
   endtask

   task automatic test_checksum();
      logic [DW-1:0] words [4];
      words[0] = 16'h0001; words[1] = 16'h0002; words[2] = 16'hFFFF; words[3] = 16'h0003;
      do_reset();
      for (int pass = 0; pass < 2; pass++) begin
         cfg_cs = (pass == 0) ? 16'h0005 : 16'h0006;
         tick(1, 0, '0, 0, 0);
         for (int i = 0; i < 4; i++) tick(0, 1, words[i], 0, 0);
         n_cmp++;
         if ({checksum_err, load_done} !== {m_err, 1'b1}) begin
            n_err++;
            $display("FAIL checksum%0d: err/load_done=%b/%b required=%b/1", pass,
                     checksum_err, load_done, m_err);
         end
`ifdef WEIGHT_CHECKSUM_EN
         n_cmp++;
         if (checksum_err !== (pass == 1)) begin
            n_err++;
            $display("FAIL checksum_fixed%0d: err=%b required=%b", pass, checksum_err, pass == 1);
         end
`endif
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) cfg_cs = 16'($urandom);
         tick($urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0, 16'($urandom),
              1'($urandom), 1'($urandom));
         n_cmp++;
         if ({bus.weight_we, bus.weight_addr, bus.weight_data, bus.s_ready, busy, load_done,
              frame_done, checksum_err, obs_gated}
             !== {e_we, e_addr, e_data, m_loading, m_loading, m_done, e_fd, m_err, exp_gated}) begin
            n_err++;
            $display("FAIL random%0d: we/addr/data=%b/%0d/%h rdy/busy/done/fd/err/gate=%b%b%b%b%b%b required %b/%0d/%h %b%b%b%b%b%b",
                     i, bus.weight_we, bus.weight_addr, bus.weight_data, bus.s_ready, busy,
                     load_done, frame_done, checksum_err, obs_gated, e_we, e_addr, e_data,
                     m_loading, m_loading, m_done, e_fd, m_err, exp_gated);
         end
      end
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      test_reset();
      test_continuous_load();
      test_gapped();
      test_gating();
      test_frames();
      test_checksum();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/weight_load_ctrl.md
Name: weight_load_ctrl

Overview:
Sequences weight loading and frame processing for one or more conv layers sharing the weight bus.
- Streams host weight words into a contiguous window of the weight memory map by driving weight_data / weight_addr / weight_we.
- Holds the conv input valid low until the window is fully written.
- Counts output pixels of the last layer and pulses frame_done at each frame boundary.
- Sits between the host/DMA weight stream and the conv chain.

Parameters:
DATA_WIDTH, 16, width of one weight word and of weight_data
ADDR_BASE, 0, first weight_addr written (layer's KERNEL_BASE_ADDR)
TOTAL_WEIGHTS, 1024, number of words in the window (kernels + bias + batchnorm A/B); must be >= 1
OUT_PIXELS, 131072, output pixels per frame at the monitored layer; must be >= 1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle pulse: begin (re)loading weights
s_data  in  DATA_WIDTH  host weight word
s_valid  in  1  s_data valid
s_ready  out  1  controller accepts s_data
weight_data  out  DATA_WIDTH  registered weight word to conv layers
weight_addr  out  32  registered weight address
weight_we  out  1  registered write strobe
i_valid  in  1  upstream pixel valid into the conv chain
i_valid_gated  out  1  i_valid AND load_done (combinational)
pix_valid  in  1  o_valid of the monitored conv layer
load_done  out  1  window fully written; conv enabled
frame_done  out  1  one-cycle pulse on the last pixel of a frame
busy  out  1  high in LOAD state
cfg_checksum  in  DATA_WIDTH  expected checksum (used only with the optional feature)
checksum_err  out  1  checksum mismatch flag

Behaviour:
- Reset (async assert, sync deassert by the environment) forces the following, and is allowed mid-load (partial writes are simply abandoned):
  - state = IDLE, all counters = 0.
  - s_ready, weight_we, load_done, frame_done, busy, checksum_err = 0.
  - weight_data = 0, weight_addr = 0.
- States:
  - IDLE: s_ready = 0. cfg_start -> LOAD, word counter cleared.
  - LOAD: busy = 1, s_ready = 1. Each accept (s_valid & s_ready) on cycle N produces, on cycle N+1, weight_we = 1, weight_addr = ADDR_BASE + k (k = 0-based accept index), weight_data = s_data. The accept with k = TOTAL_WEIGHTS-1 moves to RUN at the same edge; s_ready drops on that edge, so no extra word is taken.
  - RUN: load_done = 1, s_ready = 0. cfg_start -> LOAD: load_done clears next cycle and the pixel counter clears.
- cfg_start in LOAD is ignored; loading continues uninterrupted.
- weight_we is a single-cycle pulse per accepted word. Gaps in s_valid produce gaps in weight_we. Latency from accept to write = 1 cycle.
- Pixel counter:
  - Counts pix_valid only in RUN; pix_valid outside RUN is ignored.
  - On the pix_valid that brings the count to OUT_PIXELS: frame_done = 1 for the next cycle and the counter wraps to 0.
  - Back-to-back frames are supported with no dead cycle.
- i_valid_gated = i_valid & load_done; zero latency.
- The counters size themselves by $clog2 of their limits (minimum 1 bit). weight_addr arithmetic is 32-bit unsigned with no wrap check.

Optional Feature:
Macro WEIGHT_CHECKSUM_EN.
- Defined:
  - A DATA_WIDTH-bit running sum (mod 2^DATA_WIDTH) of accepted words, cleared on entry to LOAD.
  - On the LOAD->RUN transition, checksum_err <= (sum_including_last_word != cfg_checksum). checksum_err holds until the next cfg_start or reset.
  - load_done still asserts; the system reacts to checksum_err.
- Undefined: no accumulator; checksum_err tied 0; cfg_checksum unused.

Decomposition:
- Package weight_load_pkg:
  - state enum (IDLE, LOAD, RUN).
  - WEIGHT_ADDR_WIDTH = 32.
  - Helper function for counter width (clog2 with minimum 1).
- One natural sub-module, frame_pixel_counter: modulo-OUT_PIXELS counter with enable and a registered wrap pulse; instantiated for frame_done.
- Load sequencing stays in the top module.

Test Plan:
- Reset mid-load: ADDR_BASE=23, TOTAL_WEIGHTS=4, 2 words accepted, rst_n pulsed low -> all outputs 0, state IDLE; a new cfg_start reloads starting at weight_addr 23.
- Continuous load: ADDR_BASE=23, TOTAL_WEIGHTS=4, cfg_start then s_valid held with data 0x0101..0x0104 -> weight_we on 4 consecutive cycles, addrs 23..26, data matching; load_done high the cycle after the 4th accept; s_ready low afterwards.
- Gapped stream: s_valid toggling 1,0,1,0 -> weight_we mirrors accepts one cycle later; addresses contiguous; cfg_start during LOAD has no effect.
- Gating: i_valid = 1 throughout -> i_valid_gated = 0 until load_done, then 1; cfg_start in RUN drops it again.
- Frames: OUT_PIXELS=3, 7 pix_valid pulses in RUN -> frame_done after pulses 3 and 6 only; pix_valid before load ignored.
- WEIGHT_CHECKSUM_EN: words 0x0001,0x0002,0xFFFF,0x0003 (sum 0x0005), cfg_checksum=0x0005 -> checksum_err 0; cfg_checksum=0x0006 -> checksum_err 1 at load_done.
